dma_request_qualifier: RTL and testbench

Front-end request stage of the 8237A-style DMA controller. It synchronises the four raw DREQ pins, applies sense polarity, the channel mask register and the software request register, and presents a registered `valid_dreq[3:0]` vector to the rotating-priority channel arbiter. It also owns the mask/request register state:
- CPU register writes.
- Master clear.
- Terminal-count side effects reported by the transfer engine.

---
 rtl/dma_request_qualifier.sv | 149 ++++++++++++++
 tb/tb_dma_request_qualifier.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dma_request_qualifier.sv
// dma_request_qualifier: DREQ synchroniser, polarity, mask and software request
// qualification feeding the channel arbiter; owns the mask/request registers.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-low reset
//   dreq_raw[3:0]       asynchronous DREQ pins, bit i = channel i
//   dreq_sense_low      1 = DREQ pins are active-low
//   ctrl_disable        1 = suppress every qualified request
//   wr_en/wr_sel/wr_data  register write port
//                       (00 single mask, 01 all mask, 10 request, 11 clear mask)
//   master_clear        mask all channels, drop all software requests
//   tc_valid/tc_channel terminal-count event from the transfer engine
//   autoinit[3:0]       per-channel autoinitialize mode
//   valid_dreq[3:0]     registered qualified requests
//   mask_q[3:0]         mask register (1 = masked)
//   request_q[3:0]      software request register
//   status_req[3:0]     registered polarity-corrected DREQ, unmasked
//
// Build option: define DMA_SW_REQUEST_EN to include the software request
// register. Without it request_q is constant 0, request writes are ignored
// and terminal count only touches the mask.

module dma_request_qualifier #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] dreq_raw,
    input  logic       dreq_sense_low,
    input  logic       ctrl_disable,
    input  logic       wr_en,
    input  logic [1:0] wr_sel,
    input  logic [3:0] wr_data,
    input  logic       master_clear,
    input  logic       tc_valid,
    input  logic [1:0] tc_channel,
    input  logic [3:0] autoinit,
    output logic [3:0] valid_dreq,
    output logic [3:0] mask_q,
    output logic [3:0] request_q,
    output logic [3:0] status_req
);

    localparam logic [1:0] SEL_MASK_ONE = 2'b00;
    localparam logic [1:0] SEL_MASK_ALL = 2'b01;
    localparam logic [1:0] SEL_REQUEST  = 2'b10;
    localparam logic [1:0] SEL_MASK_CLR = 2'b11;

    // Synchroniser chain: row 0 samples the pins, the last row is sync_out.
    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [SYNC_STAGES-1:0][3:0] sync_d;

    logic [3:0] act;
    logic [3:0] mask_d;
    logic [3:0] req_d;
    logic [3:0] req_cur;
    logic [3:0] valid_dreq_q;
    logic [3:0] valid_dreq_d;
    logic [3:0] status_req_q;
    logic [3:0] status_req_d;
    logic [3:0] mask_r_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], dreq_raw};
    end

    assign act = sync_q[SYNC_STAGES-1] ^ {4{dreq_sense_low}};

    // Register update. Later assignments override earlier ones, so the
    // ordering below encodes precedence: write < TC < master clear.
    // Bits a higher-priority event does not touch keep the write result.
    always_comb begin
        mask_d = mask_r_q;
        req_d  = req_cur;

        if (wr_en) begin
            unique case (wr_sel)
                SEL_MASK_ONE: mask_d[wr_data[1:0]] = wr_data[2];
                SEL_MASK_ALL: mask_d = wr_data;
`ifdef DMA_SW_REQUEST_EN
                SEL_REQUEST:  req_d[wr_data[1:0]] = wr_data[2];
`else
                SEL_REQUEST:  req_d = req_cur;
`endif
                SEL_MASK_CLR: mask_d = 4'b0000;
                default:      mask_d = mask_r_q;
            endcase
        end

        if (tc_valid) begin
            req_d[tc_channel] = 1'b0;
            if (!autoinit[tc_channel]) begin
                mask_d[tc_channel] = 1'b1;
            end
        end

        if (master_clear) begin
            mask_d = 4'b1111;
            req_d  = 4'b0000;
        end
    end

    // Qualification uses the registered mask/request, so a register change
    // at one edge reaches valid_dreq at the following edge.
    always_comb begin
        valid_dreq_d = {4{!ctrl_disable}} & ((act & ~mask_r_q) | req_cur);
        status_req_d = act;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_q       <= '0;
            mask_r_q     <= 4'b1111;
            valid_dreq_q <= 4'b0000;
            status_req_q <= 4'b0000;
        end else begin
            sync_q       <= sync_d;
            mask_r_q     <= mask_d;
            valid_dreq_q <= valid_dreq_d;
            status_req_q <= status_req_d;
        end
    end

`ifdef DMA_SW_REQUEST_EN
    logic [3:0] req_r_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            req_r_q <= 4'b0000;
        end else begin
            req_r_q <= req_d;
        end
    end

    assign req_cur = req_r_q;
`else
    // No software request register: the next-state value is discarded and
    // the qualification term is tied off.
    logic unused_req;
    assign unused_req = ^req_d;
    assign req_cur    = 4'b0000;
`endif

    assign valid_dreq = valid_dreq_q;
    assign mask_q     = mask_r_q;
    assign request_q  = req_cur;
    assign status_req = status_req_q;

endmodule

// File: tb/tb_dma_request_qualifier.sv
// tb_dma_request_qualifier: directed vectors for dma_request_qualifier.
// Expected values are hand-derived; software-request results depend on build.

module tb_dma_request_qualifier;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] dreq_raw;
    logic       dreq_sense_low;
    logic       ctrl_disable;
    logic       wr_en;
    logic [1:0] wr_sel;
    logic [3:0] wr_data;
    logic       master_clear;
    logic       tc_valid;
    logic [1:0] tc_channel;
    logic [3:0] autoinit;
    logic [3:0] valid_dreq;
    logic [3:0] mask_q;
    logic [3:0] request_q;
    logic [3:0] status_req;

    int n_chk = 0;
    int n_bad = 0;

`ifdef DMA_SW_REQUEST_EN
    localparam bit SW = 1'b1;
`else
    localparam bit SW = 1'b0;
`endif

    always #5 clock = ~clock;

    dma_request_qualifier #(.SYNC_STAGES(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .dreq_raw       (dreq_raw),
        .dreq_sense_low (dreq_sense_low),
        .ctrl_disable   (ctrl_disable),
        .wr_en          (wr_en),
        .wr_sel         (wr_sel),
        .wr_data        (wr_data),
        .master_clear   (master_clear),
        .tc_valid       (tc_valid),
        .tc_channel     (tc_channel),
        .autoinit       (autoinit),
        .valid_dreq     (valid_dreq),
        .mask_q         (mask_q),
        .request_q      (request_q),
        .status_req     (status_req)
    );

    task automatic chk(input string tag, input logic [3:0] got,
                       input logic [3:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // One edge, then drop the one-cycle strobes; sampling is 1ns after it.
    task automatic cyc();
        @(posedge clock);
        #1;
        wr_en        = 1'b0;
        master_clear = 1'b0;
        tc_valid     = 1'b0;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [3:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_data = data;
    endtask

    initial begin
        reset          = 1'b0;
        dreq_raw       = 4'b0000;
        dreq_sense_low = 1'b0;
        ctrl_disable   = 1'b0;
        wr_en          = 1'b0;
        wr_sel         = 2'b00;
        wr_data        = 4'b0000;
        master_clear   = 1'b0;
        tc_valid       = 1'b0;
        tc_channel     = 2'b00;
        autoinit       = 4'b0000;

        cyc();
        cyc();
        chk("rst_mask", mask_q, 4'b1111);
        chk("rst_req", request_q, 4'b0000);
        chk("rst_valid", valid_dreq, 4'b0000);
        chk("rst_status", status_req, 4'b0000);

        // Clear-mask write while held in reset has no effect.
        dreq_raw = 4'b0001;
        wr(2'b11, 4'b0000);
        cyc();
        chk("rst_wr_mask", mask_q, 4'b1111);
        chk("rst_wr_valid", valid_dreq, 4'b0000);

        // Release: DREQ settled before edge N, valid after edge N+2.
        reset = 1'b1;
        wr(2'b11, 4'b0000);
        cyc();
        chk("clr_mask", mask_q, 4'b0000);
        chk("lat_e0", valid_dreq, 4'b0000);
        cyc();
        chk("lat_e1", valid_dreq, 4'b0000);
        cyc();
        chk("lat_e2", valid_dreq, 4'b0001);
        chk("lat_status", status_req, 4'b0001);

        // Active-low sense.
        dreq_sense_low = 1'b1;
        dreq_raw       = 4'b1110;
        cyc();
        cyc();
        cyc();
        chk("low_status", status_req, 4'b0001);
        chk("low_valid", valid_dreq, 4'b0001);
        ctrl_disable = 1'b1;
        cyc();
        chk("dis_valid", valid_dreq, 4'b0000);
        chk("dis_status", status_req, 4'b0001);

        // Single mask write on ch2 with all DREQs active.
        ctrl_disable   = 1'b0;
        dreq_sense_low = 1'b0;
        dreq_raw       = 4'b1111;
        cyc();
        cyc();
        cyc();
        chk("all_valid", valid_dreq, 4'b1111);
        wr(2'b00, 4'b0110);
        cyc();
        chk("m1_mask", mask_q, 4'b0100);
        chk("m1_valid_k", valid_dreq, 4'b1111);
        cyc();
        chk("m1_valid", valid_dreq, 4'b1011);

        // Software request on masked ch3, no DREQ.
        dreq_raw = 4'b0000;
        cyc();
        cyc();
        cyc();
        chk("idle_valid", valid_dreq, 4'b0000);
        wr(2'b00, 4'b1111);
        cyc();
        chk("m3_mask", mask_q, 4'b1100);
        wr(2'b10, 4'b0111);
        cyc();
        chk("sw_req", request_q, SW ? 4'b1000 : 4'b0000);
        cyc();
        chk("sw_valid", valid_dreq, SW ? 4'b1000 : 4'b0000);
        tc_valid   = 1'b1;
        tc_channel = 2'd3;
        autoinit   = 4'b0000;
        cyc();
        chk("tc3_req", request_q, 4'b0000);
        chk("tc3_mask", mask_q, 4'b1100);
        cyc();
        chk("tc3_valid", valid_dreq, 4'b0000);

        // TC without autoinit sets the channel mask.
        tc_valid   = 1'b1;
        tc_channel = 2'd0;
        cyc();
        chk("tc0_mask", mask_q, 4'b1101);

        // TC ch1 with autoinit beats a same-cycle request-set on ch1.
        wr(2'b11, 4'b0000);
        cyc();
        chk("clr2_mask", mask_q, 4'b0000);
        autoinit   = 4'b0010;
        tc_valid   = 1'b1;
        tc_channel = 2'd1;
        wr(2'b10, 4'b0101);
        cyc();
        chk("tc1_req", request_q, 4'b0000);
        chk("tc1_mask", mask_q, 4'b0000);

        // TC mask-set on ch2 beats a same-cycle mask-clear write on ch2.
        autoinit   = 4'b0000;
        tc_valid   = 1'b1;
        tc_channel = 2'd2;
        wr(2'b00, 4'b0010);
        cyc();
        chk("tc2_mask", mask_q, 4'b0100);

        // Write to a channel other than the TC channel still lands.
        tc_valid   = 1'b1;
        tc_channel = 2'd1;
        wr(2'b10, 4'b0110);
        cyc();
        chk("tc1b_req", request_q, SW ? 4'b0100 : 4'b0000);
        chk("tc1b_mask", mask_q, 4'b0110);

        // Master clear beats a same-cycle clear-mask write.
        master_clear = 1'b1;
        wr(2'b11, 4'b0000);
        cyc();
        chk("mc_mask", mask_q, 4'b1111);
        chk("mc_req", request_q, 4'b0000);

        // Mid-traffic reset.
        wr(2'b11, 4'b0000);
        dreq_raw = 4'b1011;
        cyc();
        wr(2'b10, 4'b0110);
        cyc();
        cyc();
        cyc();
        chk("pre_valid", valid_dreq, 4'b1011 | (SW ? 4'b0100 : 4'b0000));
        chk("pre_status", status_req, 4'b1011);
        reset = 1'b0;
        cyc();
        chk("mid_valid", valid_dreq, 4'b0000);
        chk("mid_status", status_req, 4'b0000);
        chk("mid_mask", mask_q, 4'b1111);
        chk("mid_req", request_q, 4'b0000);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
